adc_code_averager: RTL and testbench

- Sits directly downstream of the 3-bit flash ADC.
- Registers the ADC's combinational code Q on a sample strobe and accumulates 2^LOG2_AVG samples per window.
- Presents the rounded window average and the raw sum to the digital back-end over a valid/ready handshake.
- Double-buffered, so accumulation continues while a result waits for the consumer.

---
 rtl/adc_avg_pkg.sv | 24 ++
 rtl/adc_avg_round.sv | 26 ++
 rtl/adc_code_averager.sv | 132 +++++++++++++
 tb/tb_adc_code_averager.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : adc_avg_pkg                                                 |
// | Brief  : Shared types and defaults for the ADC code averager.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package adc_avg_pkg;

    localparam int c_default_n_bits   = 3;
    localparam int c_default_log2_avg = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } avg_state_t;

    // Sum of 2^log2_avg codes of n_bits each never needs more than this.
    function automatic int acc_width(input int n_bits, input int log2_avg);
        return n_bits + log2_avg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_round.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : adc_avg_round                                               |
// | Brief  : Combinational window sum to round-half-up average.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module adc_avg_round
    import adc_avg_pkg::*;
#(
    parameter int N_BITS   = c_default_n_bits,
    parameter int LOG2_AVG = c_default_log2_avg
) (
    input  logic [acc_width(N_BITS, LOG2_AVG)-1:0] sum,
    output logic [N_BITS-1:0]                      avg
);

    localparam int c_acc_w = acc_width(N_BITS, LOG2_AVG);
    localparam logic [c_acc_w-1:0] c_half =
        {{(c_acc_w-1){1'b0}}, 1'b1} << (LOG2_AVG - 1);

    // Adding half can't carry out: max sum + half < 2^c_acc_w.
    assign avg = N_BITS'((sum + c_half) >> LOG2_AVG);

endmodule
`default_nettype wire

// File: rtl/adc_code_averager.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : adc_code_averager                                           |
// | Brief  : Windowed averager for flash ADC codes with double-buffered  |
// |          valid/ready result. ADC_AVG_MINMAX_EN adds min/max outputs. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module adc_code_averager
    import adc_avg_pkg::*;
#(
    parameter int N_BITS   = c_default_n_bits,
    parameter int LOG2_AVG = c_default_log2_avg
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [N_BITS-1:0]          q_in,
    input  logic                       clear_ovr,
    input  logic                       avg_ready,
    output logic                       avg_valid,
    output logic [N_BITS-1:0]          avg_out,
    output logic [N_BITS+LOG2_AVG-1:0] sum_out,
`ifdef ADC_AVG_MINMAX_EN
    output logic [N_BITS-1:0]          min_out,
    output logic [N_BITS-1:0]          max_out,
`endif
    output logic                       overrun
);

    localparam int c_acc_w = acc_width(N_BITS, LOG2_AVG);

    logic [c_acc_w-1:0]  r_acc;
    logic [LOG2_AVG-1:0] r_cnt;
    avg_state_t          r_state;
    logic                w_last;
    logic [c_acc_w-1:0]  w_sum;
    logic [N_BITS-1:0]   w_avg;
    logic                w_load;
    logic                w_drop;

    assign w_last = sample_en && (r_cnt == '1);
    assign w_sum  = r_acc + c_acc_w'(q_in);
    // A completion is taken when the result slot is free or being freed now.
    assign w_load = w_last && ((r_state == EMPTY) || avg_ready);
    assign w_drop = w_last && (r_state == FULL) && !avg_ready;

    adc_avg_round #(
        .N_BITS   (N_BITS),
        .LOG2_AVG (LOG2_AVG)
    ) u_round (
        .sum (w_sum),
        .avg (w_avg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= EMPTY;
            avg_valid <= 1'b0;
            avg_out   <= '0;
            sum_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (sample_en) begin
                r_acc <= w_last ? '0 : w_sum;
                r_cnt <= r_cnt + LOG2_AVG'(1);
            end

            case (r_state)
                EMPTY: begin
                    if (w_last) begin
                        r_state   <= FULL;
                        avg_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (avg_ready && !w_last) begin
                        r_state   <= EMPTY;
                        avg_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    avg_valid <= 1'b0;
                end
            endcase

            if (w_load) begin
                sum_out <= w_sum;
                avg_out <= w_avg;
            end

            if (w_drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef ADC_AVG_MINMAX_EN
    logic [N_BITS-1:0] r_min;
    logic [N_BITS-1:0] r_max;
    logic [N_BITS-1:0] w_min_next;
    logic [N_BITS-1:0] w_max_next;

    assign w_min_next = (q_in < r_min) ? q_in : r_min;
    assign w_max_next = (q_in > r_max) ? q_in : r_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min   <= '1;
            r_max   <= '0;
            min_out <= '0;
            max_out <= '0;
        end else begin
            if (sample_en) begin
                r_min <= w_last ? '1 : w_min_next;
                r_max <= w_last ? '0 : w_max_next;
            end
            if (w_load) begin
                min_out <= w_min_next;
                max_out <= w_max_next;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_code_averager.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : tb_adc_code_averager                                        |
// | Brief  : Directed self-checking bench for adc_code_averager.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_adc_code_averager;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [2:0] q_in;
    logic       clear_ovr;
    logic       avg_ready;
    logic       avg_valid;
    logic [2:0] avg_out;
    logic [4:0] sum_out;
    logic       overrun;
`ifdef ADC_AVG_MINMAX_EN
    logic [2:0] min_out;
    logic [2:0] max_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_code_averager #(
        .N_BITS   (3),
        .LOG2_AVG (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .q_in      (q_in),
        .clear_ovr (clear_ovr),
        .avg_ready (avg_ready),
        .avg_valid (avg_valid),
        .avg_out   (avg_out),
        .sum_out   (sum_out),
`ifdef ADC_AVG_MINMAX_EN
        .min_out   (min_out),
        .max_out   (max_out),
`endif
        .overrun   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] q);
        sample_en = 1'b1;
        q_in      = q;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        avg_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'($urandom_range(0, 1));
            q_in      = 3'($urandom_range(0, 7));
            tick();
        end
        sample_en = 1'b0;
        rst_n = 1'b1;
        tick();
        total++;
        if ({avg_valid, avg_out, sum_out, overrun} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b avg=%0d sum=%0d ovr=%0b required all 0",
                     avg_valid, avg_out, sum_out, overrun);
        end
`ifdef ADC_AVG_MINMAX_EN
        total++;
        if (min_out !== 3'd0 || max_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_minmax: got min=%0d max=%0d required 0/0", min_out, max_out);
        end
`endif
        send(3'd1); send(3'd1); send(3'd1);
        total++;
        if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_three_samples_valid: got %0b required 0", avg_valid);
        end
        send(3'd1);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd4 || avg_out !== 3'd1) begin
            bad++;
            $display("FAIL reset_first_window: got v=%0b sum=%0d avg=%0d required 1/4/1",
                     avg_valid, sum_out, avg_out);
        end
        tick();
    endtask

    task automatic test_basic();
        avg_ready = 1'b1;
        send(3'd1); send(3'd2); send(3'd3);
        total++;
        if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: got %0b required 0", avg_valid);
        end
        send(3'd4);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd10 || avg_out !== 3'd3) begin
            bad++;
            $display("FAIL basic_window: got v=%0b sum=%0d avg=%0d required 1/10/3",
                     avg_valid, sum_out, avg_out);
        end
`ifdef ADC_AVG_MINMAX_EN
        total++;
        if (min_out !== 3'd1 || max_out !== 3'd4) begin
            bad++;
            $display("FAIL basic_minmax: got min=%0d max=%0d required 1/4", min_out, max_out);
        end
`endif
        tick();
        total++;
        if (avg_valid !== 1'b0 || sum_out !== 5'd10) begin
            bad++;
            $display("FAIL basic_valid_drop: got v=%0b sum=%0d required 0/10", avg_valid, sum_out);
        end
    endtask

    task automatic test_full_scale();
        avg_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(3'd7);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd28 || avg_out !== 3'd7) begin
            bad++;
            $display("FAIL full_scale_max: got v=%0b sum=%0d avg=%0d required 1/28/7",
                     avg_valid, sum_out, avg_out);
        end
        tick();
        for (int i = 0; i < 4; i++) send(3'd0);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd0 || avg_out !== 3'd0) begin
            bad++;
            $display("FAIL full_scale_zero: got v=%0b sum=%0d avg=%0d required 1/0/0",
                     avg_valid, sum_out, avg_out);
        end
        tick();
    endtask

    task automatic test_sparse();
        logic [2:0] codes [4];
        int         gaps  [4];
        codes = '{3'd2, 3'd2, 3'd3, 3'd3};
        gaps  = '{1, 3, 0, 2};
        avg_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(codes[i]);
            for (int g = 0; g < gaps[i]; g++) tick();
        end
        total++;
        if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL sparse_idle_no_advance: got v=%0b required 0", avg_valid);
        end
        send(codes[3]);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd10 || avg_out !== 3'd3) begin
            bad++;
            $display("FAIL sparse_window: got v=%0b sum=%0d avg=%0d required 1/10/3",
                     avg_valid, sum_out, avg_out);
        end
        tick();
    endtask

    task automatic test_backpressure();
        avg_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd1);
        for (int i = 0; i < 4; i++) send(3'd6);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd4 || avg_out !== 3'd1 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL bp_overrun: got v=%0b sum=%0d avg=%0d ovr=%0b required 1/4/1/1",
                     avg_valid, sum_out, avg_out, overrun);
        end
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
        total++;
        if (avg_valid !== 1'b0 || sum_out !== 5'd4 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL bp_consume: got v=%0b sum=%0d ovr=%0b required 0/4/1",
                     avg_valid, sum_out, overrun);
        end
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL bp_clear_ovr: got %0b required 0", overrun);
        end
        for (int i = 0; i < 4; i++) send(3'd1);
        for (int i = 0; i < 3; i++) send(3'd6);
        avg_ready = 1'b1;
        send(3'd6);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd24 || avg_out !== 3'd6 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_on_completion: got v=%0b sum=%0d avg=%0d ovr=%0b required 1/24/6/0",
                     avg_valid, sum_out, avg_out, overrun);
        end
        tick();
        avg_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd2);
        for (int i = 0; i < 3; i++) send(3'd5);
        clear_ovr = 1'b1;
        send(3'd5);
        clear_ovr = 1'b0;
        total++;
        if (overrun !== 1'b1 || sum_out !== 5'd8) begin
            bad++;
            $display("FAIL bp_set_beats_clear: got ovr=%0b sum=%0d required 1/8", overrun, sum_out);
        end
        avg_ready = 1'b1;
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
    endtask

    task automatic test_reset_mid_window();
        avg_ready = 1'b1;
        send(3'd7); send(3'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(3'd5);
        total++;
        if (avg_valid !== 1'b1 || sum_out !== 5'd20 || avg_out !== 3'd5) begin
            bad++;
            $display("FAIL reset_mid_window: got v=%0b sum=%0d avg=%0d required 1/20/5",
                     avg_valid, sum_out, avg_out);
        end
`ifdef ADC_AVG_MINMAX_EN
        total++;
        if (min_out !== 3'd5 || max_out !== 3'd5) begin
            bad++;
            $display("FAIL reset_mid_minmax: got min=%0d max=%0d required 5/5", min_out, max_out);
        end
`endif
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b0;
        q_in      = '0;
        clear_ovr = 1'b0;
        avg_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_scale();
        test_sparse();
        test_backpressure();
        test_reset_mid_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
